aux_input_conditioner: RTL and testbench

//   Board-input front end that feeds the top-level core wrapper. Synchronises, debounces
//   and edge-detects the raw resume button and the 16 slide switches. Outputs are clean,
//   clk-domain signals: the resume pulse drives the halt/resume controller; the switches

---
 rtl/aux_input_conditioner_pkg.sv | 42 ++++
 rtl/aux_input_conditioner_debounce.sv | 74 +++++++
 rtl/aux_input_conditioner.sv | 83 ++++++++
 tb/tb_aux_input_conditioner.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/aux_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aux_input_conditioner_pkg
//  Description : Shared constants, types and helpers for the board-input
//                conditioner: default parameter values, the debounce decision
//                and a millisecond-to-cycle-count helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aux_input_conditioner_pkg;

    localparam int c_swt_bit_default      = 16;
    localparam int c_debounce_cnt_default = 1_000_000;
    localparam int c_sync_stages_default  = 2;

    // What a debounce tick does to the stored level.
    typedef enum logic [1:0] {
        DEB_HOLD = 2'd0,
        DEB_SET  = 2'd1,
        DEB_CLR  = 2'd2
    } deb_action_e;

    // window = {two previous tick samples, current synchronised sample}.
    // Only three agreeing samples move the level.
    function automatic deb_action_e deb_action(input logic [2:0] window);
        deb_action_e act;
        act = DEB_HOLD;
        if (&window) begin
            act = DEB_SET;
        end else if (~|window) begin
            act = DEB_CLR;
        end
        return act;
    endfunction

    // Debounce sample period in clk cycles for a given clock and period.
    function automatic int unsigned cnt_ms(input int unsigned clk_hz,
                                           input int unsigned ms);
        return (clk_hz / 32'd1000) * ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aux_input_conditioner_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : aux_debounce_bit
//  Description : One input lane: SYNC_STAGES synchroniser, 2-sample tick
//                history, debounced level flop and registered rise/fall
//                strobes that coincide with the level change.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                i_raw        - asynchronous raw input
//                i_tick       - shared debounce sample strobe
//                o_deb        - debounced level
//                o_rise/o_fall- one-cycle strobes in the first cycle of a
//                               new level
//  Revision    : 1.0 - initial release
// ============================================================================
module aux_debounce_bit
    import aux_input_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = c_sync_stages_default
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    input  logic i_tick,
    output logic o_deb,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [1:0]             r_hist;
    logic                   r_deb;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_sync_x;
    deb_action_e            w_action;

    assign w_sync_x = r_sync[SYNC_STAGES-1];
    assign w_action = deb_action({r_hist, w_sync_x});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_hist <= '0;
            r_deb  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (i_tick) begin
                r_hist <= {r_hist[0], w_sync_x};
                case (w_action)
                    DEB_SET: begin
                        r_deb  <= 1'b1;
                        r_rise <= ~r_deb;
                    end
                    DEB_CLR: begin
                        r_deb  <= 1'b0;
                        r_fall <= r_deb;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_deb  = r_deb;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/aux_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : aux_input_conditioner
//  Description : Board-input front end. Synchronises, debounces and
//                edge-detects the resume button and the slide switches.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                resume_raw    - raw resume button
//                swt_raw       - raw slide switches [SWT_BIT-1:0]
//                resume_level  - debounced resume level
//                resume_pulse  - one cycle on debounced resume rising edge
//                swt           - debounced switches
//                swt_changed   - one cycle when any debounced switch changes
//  Revision    : 1.0 - initial release
// ============================================================================
module aux_input_conditioner
    import aux_input_conditioner_pkg::*;
#(
    parameter int SWT_BIT      = c_swt_bit_default,
    parameter int DEBOUNCE_CNT = c_debounce_cnt_default,
    parameter int SYNC_STAGES  = c_sync_stages_default
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               resume_raw,
    input  logic [SWT_BIT-1:0] swt_raw,
    output logic               resume_level,
    output logic               resume_pulse,
    output logic [SWT_BIT-1:0] swt,
    output logic               swt_changed
);

    localparam int                c_tc_w   = $clog2(DEBOUNCE_CNT);
    localparam logic [c_tc_w-1:0] c_tc_max = c_tc_w'(DEBOUNCE_CNT - 1);

    logic [c_tc_w-1:0] r_tc;
    logic              w_tick;
    logic [SWT_BIT:0]  w_raw;
    logic [SWT_BIT:0]  w_deb;
    logic [SWT_BIT:0]  w_rise;
    logic [SWT_BIT:0]  w_fall;
    logic              w_unused_resume_fall;

    // Shared prescaler: one sample strobe every DEBOUNCE_CNT cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tc <= '0;
        end else if (r_tc == c_tc_max) begin
            r_tc <= '0;
        end else begin
            r_tc <= r_tc + 1'b1;
        end
    end

    assign w_tick = (r_tc == c_tc_max);

    // Lane SWT_BIT is the resume button, lanes below are the switches.
    assign w_raw = {resume_raw, swt_raw};

    for (genvar gi = 0; gi <= SWT_BIT; gi++) begin : g_bit
        aux_debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (w_raw[gi]),
            .i_tick (w_tick),
            .o_deb  (w_deb[gi]),
            .o_rise (w_rise[gi]),
            .o_fall (w_fall[gi])
        );
    end

    assign resume_level = w_deb[SWT_BIT];
    assign resume_pulse = w_rise[SWT_BIT];
    assign swt          = w_deb[SWT_BIT-1:0];
    // Strobes are flops, so the OR is clean and lands in the change cycle.
    assign swt_changed  = |(w_rise[SWT_BIT-1:0] | w_fall[SWT_BIT-1:0]);

    // A resume release is deliberately silent.
    assign w_unused_resume_fall = w_fall[SWT_BIT];

endmodule
`default_nettype wire

// File: tb/tb_aux_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aux_input_conditioner
//  Description : Scoreboard bench for aux_input_conditioner (DEBOUNCE_CNT=4,
//                SYNC_STAGES=2). A tick-level reference model pushes expected
//                output events; a negedge monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aux_input_conditioner;

    localparam int c_n  = 4;
    localparam int c_s  = 2;
    localparam int c_sw = 16;

    typedef struct {
        int          cyc;
        logic        rl;
        logic        rp;
        logic [15:0] sw;
        logic        sc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        resume_raw = 1'b0;
    logic [15:0] swt_raw = 16'h0000;
    logic        resume_level;
    logic        resume_pulse;
    logic [15:0] swt;
    logic        swt_changed;

    int errors = 0;
    int checks = 0;

    exp_t        q[$];
    logic [16:0] rq[$];
    logic [16:0] m_deb;
    logic [16:0] run_val;
    int          run_len[17];
    int          edge_idx = -1;
    bit          rst_seen = 1'b1;
    logic        prev_rl;
    logic [15:0] prev_sw;

    aux_input_conditioner #(
        .SWT_BIT      (c_sw),
        .DEBOUNCE_CNT (c_n),
        .SYNC_STAGES  (c_s)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .resume_raw   (resume_raw),
        .swt_raw      (swt_raw),
        .resume_level (resume_level),
        .resume_pulse (resume_pulse),
        .swt          (swt),
        .swt_changed  (swt_changed)
    );

    always #5 clk = ~clk;

    // Reference model: raw inputs appear c_s edges late; every c_n-th edge
    // after reset is a sample; a level follows the input once it has seen
    // three equal samples in a row.
    always @(posedge clk) begin
        logic [16:0] raw;
        logic [16:0] smp;
        logic [16:0] old;
        exp_t        e;
        if (rst) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL leftover_events: got %0d pending, required 0", q.size());
            end
            q.delete();
            rq.delete();
            for (int i = 0; i < c_s; i++) rq.push_back(17'h0);
            m_deb   = '0;
            run_val = '0;
            for (int i = 0; i < 17; i++) run_len[i] = 0;
            edge_idx = -1;
            rst_seen = 1'b1;
        end else begin
            rst_seen = 1'b0;
            edge_idx++;
            raw = {resume_raw, swt_raw};
            smp = rq.pop_front();
            rq.push_back(raw);
            if ((edge_idx % c_n) == c_n - 1) begin
                old = m_deb;
                for (int i = 0; i < 17; i++) begin
                    if (run_len[i] > 0 && smp[i] == run_val[i]) begin
                        run_len[i]++;
                    end else begin
                        run_val[i] = smp[i];
                        run_len[i] = 1;
                    end
                    if (run_len[i] >= 3) m_deb[i] = run_val[i];
                end
                if (m_deb != old) begin
                    e.cyc = edge_idx;
                    e.rl  = m_deb[16];
                    e.rp  = m_deb[16] & ~old[16];
                    e.sw  = m_deb[15:0];
                    e.sc  = (m_deb[15:0] != old[15:0]);
                    q.push_back(e);
                end
            end
        end
    end

    // Monitor: an output event is any pulse or any level change.
    always @(negedge clk) begin
        exp_t e;
        if (rst_seen) begin
            checks++;
            if ({resume_level, resume_pulse, swt, swt_changed} != 19'h0) begin
                errors++;
                $display("FAIL reset_outputs: got rl=%b rp=%b swt=%h sc=%b, required all 0",
                         resume_level, resume_pulse, swt, swt_changed);
            end
            prev_rl = 1'b0;
            prev_sw = 16'h0;
        end else begin
            if (resume_pulse || swt_changed || resume_level != prev_rl || swt != prev_sw) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: cyc=%0d got rl=%b rp=%b swt=%h sc=%b, required no event",
                             edge_idx, resume_level, resume_pulse, swt, swt_changed);
                end else begin
                    e = q.pop_front();
                    if (e.cyc != edge_idx || e.rl !== resume_level || e.rp !== resume_pulse ||
                        e.sw !== swt || e.sc !== swt_changed) begin
                        errors++;
                        $display("FAIL event: got cyc=%0d rl=%b rp=%b swt=%h sc=%b, required cyc=%0d rl=%b rp=%b swt=%h sc=%b",
                                 edge_idx, resume_level, resume_pulse, swt, swt_changed,
                                 e.cyc, e.rl, e.rp, e.sw, e.sc);
                    end
                end
                prev_rl = resume_level;
                prev_sw = swt;
            end
            if (q.size() != 0 && q[0].cyc < edge_idx) begin
                checks++;
                errors++;
                $display("FAIL missed_event: got none by cyc=%0d, required rl=%b rp=%b swt=%h sc=%b at cyc=%0d",
                         edge_idx, q[0].rl, q[0].rp, q[0].sw, q[0].sc, q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    task automatic cyc_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // 1: reset with everything held high, then release and let it settle.
        rst        = 1'b1;
        swt_raw    = 16'hFFFF;
        resume_raw = 1'b1;
        cyc_wait(5);
        rst = 1'b0;
        cyc_wait(16);
        swt_raw    = 16'h0000;
        resume_raw = 1'b0;
        cyc_wait(16);

        // 2: clean resume press from a fresh reset.
        rst = 1'b1;
        cyc_wait(2);
        rst        = 1'b0;
        resume_raw = 1'b1;
        cyc_wait(20);
        resume_raw = 1'b0;
        cyc_wait(16);

        // 3: short resume glitch.
        cyc_wait(4);
        resume_raw = 1'b1;
        cyc_wait(3);
        resume_raw = 1'b0;
        cyc_wait(16);

        // 4: chattering switches, then settled at 16'h0003.
        for (int i = 0; i < 20; i++) begin
            swt_raw = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
            cyc_wait(1);
        end
        swt_raw = 16'h0003;
        cyc_wait(20);

        // 5: resume and swt[5] rise together.
        swt_raw = 16'h0000;
        cyc_wait(16);
        resume_raw = 1'b1;
        swt_raw    = 16'h0020;
        cyc_wait(20);

        // 6: reset part-way through a debounce.
        swt_raw = 16'h0100;
        cyc_wait(9);
        rst = 1'b1;
        cyc_wait(1);
        rst = 1'b0;
        cyc_wait(20);

        // Randomised traffic with occasional resets.
        for (int it = 0; it < 250; it++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                cyc_wait(1 + $urandom_range(0, 2));
                rst = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                swt_raw = 16'($urandom);
            end else begin
                swt_raw = swt_raw ^ (16'h0001 << $urandom_range(0, 15));
            end
            resume_raw = 1'($urandom_range(0, 1));
            cyc_wait($urandom_range(1, 14));
        end
        cyc_wait(20);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL final_pending: got %0d pending events, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
